// File: rtl/bp_be_pkg.sv
// Shared types for the Sv39 backend page-table walker: FSM states, PTE, TLB entry, fault packet.
// Also provides the BP_BE_PTW_PKT_WIDTH macro that sizes the walker's fault packet port.
`ifndef BP_BE_PKG_SVH_
`define BP_BE_PKG_SVH_
`define BP_BE_PTW_PKT_WIDTH(vaddr_width_mp) (3 + (vaddr_width_mp))
`endif

package bp_be_pkg;

   localparam int sv39_vpn_width_lp  = 9;
   localparam int sv39_ppn_width_lp  = 44;
   localparam int page_offset_lp     = 12;

   typedef enum logic [2:0] {
      e_ptw_idle  = 3'd0,
      e_ptw_send  = 3'd1,
      e_ptw_wait  = 3'd2,
      e_ptw_done  = 3'd3,
      e_ptw_fault = 3'd4
   } bp_be_ptw_state_e;

   typedef struct packed {
      logic [9:0]  reserved;
      logic [43:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } bp_sv39_pte_s;

   typedef struct packed {
      logic [43:0] ptag;
      logic [1:0]  size;
      logic        u;
      logic        g;
      logic        r;
      logic        w;
      logic        x;
   } bp_be_tlb_entry_s;

   typedef struct packed {
      logic        instr_page_fault_v;
      logic        load_page_fault_v;
      logic        store_page_fault_v;
      logic [38:0] vaddr;
   } bp_be_ptw_pkt_s;

   // Picks the 9-bit VPN slice that indexes the page table at the given level.
   function automatic logic [8:0] sv39_vpn(input logic [26:0] vpn, input logic [1:0] level);
      logic [8:0] slice;
      case (level)
         2'd0:    slice = vpn[8:0];
         2'd1:    slice = vpn[17:9];
         default: slice = vpn[26:18];
      endcase
      return slice;
   endfunction

endpackage

// File: rtl/bp_be_ptw_pte_check.sv
// Combinational Sv39 PTE decode: leaf detection, invalid encodings and misaligned superpages.
module bp_be_ptw_pte_check
   import bp_be_pkg::*;
(
   input  logic [63:0] pte,
   input  logic [1:0]  level,
   input  logic        store,
   output logic        leaf,
   output logic        invalid,
   output logic        misaligned
);

   bp_sv39_pte_s pte_s;
   logic         unused_s;

   assign pte_s    = pte;
   assign unused_s = ^{pte_s.reserved, pte_s.ppn[43:18], pte_s.rsw, pte_s.g, pte_s.u};

   // A leaf superpage must have the PPN fields below its level cleared.
   always_comb begin
      leaf    = pte_s.r | pte_s.x;
      invalid = ~pte_s.v | (~pte_s.r & pte_s.w) | ~pte_s.a | (store & ~pte_s.d);
      case (level)
         2'd2:    misaligned = leaf & (pte_s.ppn[17:0] != 18'd0);
         2'd1:    misaligned = leaf & (pte_s.ppn[8:0] != 9'd0);
         default: misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/bp_be_ptw.sv
// Sv39 hardware page-table walker: one PTE load per level, TLB fill or page-fault packet.
// Define BP_BE_PTW_SUPERPAGE_EN to allow 1GB/2MB leaves; otherwise any leaf above level 0 faults.
module bp_be_ptw
   import bp_be_pkg::*;
#(
   parameter int vaddr_width_p = 39,
   parameter int paddr_width_p = 56
)(
   input  logic                                         clk_i,
   input  logic                                         reset_n_i,
   input  logic                                         miss_v_i,
   output logic                                         miss_ready_o,
   input  logic [vaddr_width_p-1:0]                     miss_vaddr_i,
   input  logic                                         miss_instr_i,
   input  logic                                         miss_store_i,
   input  logic [43:0]                                  satp_ppn_i,
   input  logic                                         flush_i,
   output logic                                         busy_o,
   output logic                                         mem_req_v_o,
   input  logic                                         mem_req_ready_i,
   output logic [paddr_width_p-1:0]                     mem_req_paddr_o,
   input  logic                                         mem_rsp_v_i,
   input  logic [63:0]                                  mem_rsp_data_i,
   output logic                                         tlb_w_v_o,
   output logic [vaddr_width_p-13:0]                    tlb_w_vtag_o,
   output logic [paddr_width_p-6:0]                     tlb_w_entry_o,
   output logic [`BP_BE_PTW_PKT_WIDTH(vaddr_width_p)-1:0] ptw_pkt_o
);

   localparam int ptag_width_lp = paddr_width_p - 12;
   localparam int vtag_width_lp = vaddr_width_p - 12;
   localparam int pkt_width_lp  = `BP_BE_PTW_PKT_WIDTH(vaddr_width_p);

   bp_be_ptw_state_e          state_r;
   logic [vaddr_width_p-1:0]  vaddr_r;
   logic                      instr_r;
   logic                      store_r;
   logic [1:0]                level_r;
   logic [1:0]                drop_cnt_r;
   logic                      miss_ready_r;
   logic                      busy_r;
   logic                      mem_req_v_r;
   logic [paddr_width_p-1:0]  mem_req_paddr_r;
   logic                      tlb_w_v_r;
   logic [vtag_width_lp-1:0]  tlb_w_vtag_r;
   logic [paddr_width_p-6:0]  tlb_w_entry_r;
   logic [pkt_width_lp-1:0]   ptw_pkt_r;

   bp_sv39_pte_s              rsp_pte_s;
   logic                      leaf_s;
   logic                      invalid_s;
   logic                      misaligned_s;
   logic                      superpage_fault_s;
   logic [1:0]                fill_size_s;
   logic                      accept_s;
   logic                      fire_s;
   logic                      rsp_s;
   logic                      drop_hit_s;
   logic                      own_out_s;
   logic [1:0]                drop_next_s;
   logic [1:0]                next_level_s;
   logic [ptag_width_lp-1:0]  next_ppn_s;
   logic [paddr_width_p-1:0]  accept_paddr_s;
   logic [paddr_width_p-1:0]  descend_paddr_s;
   logic [pkt_width_lp-1:0]   fault_pkt_s;
   logic                      unused_s;

   assign rsp_pte_s = mem_rsp_data_i;
   assign unused_s  = ^{rsp_pte_s.reserved, rsp_pte_s.rsw, rsp_pte_s.d, rsp_pte_s.a, rsp_pte_s.v};

   bp_be_ptw_pte_check pte_check (
      .pte        (mem_rsp_data_i),
      .level      (level_r),
      .store      (store_r),
      .leaf       (leaf_s),
      .invalid    (invalid_s),
      .misaligned (misaligned_s)
   );

`ifdef BP_BE_PTW_SUPERPAGE_EN
   assign superpage_fault_s = misaligned_s;
   assign fill_size_s       = level_r;
`else
   logic unused_misaligned_s;
   assign unused_misaligned_s = misaligned_s;
   assign superpage_fault_s   = leaf_s & (level_r != 2'd0);
   assign fill_size_s         = 2'd0;
`endif

   assign accept_s        = miss_v_i & miss_ready_r & ~flush_i;
   assign fire_s          = mem_req_v_r & mem_req_ready_i;
   assign drop_hit_s      = mem_rsp_v_i & (drop_cnt_r != 2'd0);
   assign rsp_s           = (state_r == e_ptw_wait) & mem_rsp_v_i & (drop_cnt_r == 2'd0);
   assign own_out_s       = ((state_r == e_ptw_wait) & ~rsp_s) | ((state_r == e_ptw_send) & fire_s);
   assign next_level_s    = level_r - 2'd1;
   assign next_ppn_s      = rsp_pte_s.ppn[ptag_width_lp-1:0];
   assign accept_paddr_s  = {satp_ppn_i[ptag_width_lp-1:0], sv39_vpn(miss_vaddr_i[38:12], 2'd2), 3'b000};
   assign descend_paddr_s = {next_ppn_s, sv39_vpn(vaddr_r[38:12], next_level_s), 3'b000};
   assign fault_pkt_s     = {instr_r, ~instr_r & ~store_r, ~instr_r & store_r, vaddr_r};

   // Responses still owed to aborted walks; each one that arrives is swallowed.
   always_comb begin
      drop_next_s = drop_cnt_r;
      if (drop_hit_s) begin
         drop_next_s = drop_next_s - 2'd1;
      end else begin
         drop_next_s = drop_next_s;
      end
      if (flush_i & own_out_s & (drop_next_s != 2'd3)) begin
         drop_next_s = drop_next_s + 2'd1;
      end else begin
         drop_next_s = drop_next_s;
      end
   end

   // Walker FSM with all outputs registered; fill and fault are single-cycle pulses.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r         <= e_ptw_idle;
         vaddr_r         <= {vaddr_width_p{1'b0}};
         instr_r         <= 1'b0;
         store_r         <= 1'b0;
         level_r         <= 2'd0;
         drop_cnt_r      <= 2'd0;
         miss_ready_r    <= 1'b1;
         busy_r          <= 1'b0;
         mem_req_v_r     <= 1'b0;
         mem_req_paddr_r <= {paddr_width_p{1'b0}};
         tlb_w_v_r       <= 1'b0;
         tlb_w_vtag_r    <= {vtag_width_lp{1'b0}};
         tlb_w_entry_r   <= {(paddr_width_p-5){1'b0}};
         ptw_pkt_r       <= {pkt_width_lp{1'b0}};
      end else begin
         tlb_w_v_r  <= 1'b0;
         ptw_pkt_r  <= {pkt_width_lp{1'b0}};
         drop_cnt_r <= drop_next_s;
         if (flush_i) begin
            state_r      <= e_ptw_idle;
            miss_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            mem_req_v_r  <= 1'b0;
         end else begin
            case (state_r)
               e_ptw_idle: begin
                  if (accept_s) begin
                     vaddr_r         <= miss_vaddr_i;
                     instr_r         <= miss_instr_i;
                     store_r         <= miss_store_i & ~miss_instr_i;
                     level_r         <= 2'd2;
                     mem_req_paddr_r <= accept_paddr_s;
                     mem_req_v_r     <= 1'b1;
                     miss_ready_r    <= 1'b0;
                     busy_r          <= 1'b1;
                     state_r         <= e_ptw_send;
                  end else begin
                     state_r <= e_ptw_idle;
                  end
               end
               e_ptw_send: begin
                  if (fire_s) begin
                     mem_req_v_r <= 1'b0;
                     state_r     <= e_ptw_wait;
                  end else begin
                     state_r <= e_ptw_send;
                  end
               end
               e_ptw_wait: begin
                  if (!rsp_s) begin
                     state_r <= e_ptw_wait;
                  end else if (invalid_s | superpage_fault_s | (~leaf_s & (level_r == 2'd0))) begin
                     ptw_pkt_r <= fault_pkt_s;
                     state_r   <= e_ptw_fault;
                  end else if (!leaf_s) begin
                     level_r         <= next_level_s;
                     mem_req_paddr_r <= descend_paddr_s;
                     mem_req_v_r     <= 1'b1;
                     state_r         <= e_ptw_send;
                  end else begin
                     tlb_w_v_r     <= 1'b1;
                     tlb_w_vtag_r  <= vaddr_r[vaddr_width_p-1:12];
                     tlb_w_entry_r <= {next_ppn_s, fill_size_s, rsp_pte_s.u, rsp_pte_s.g,
                                       rsp_pte_s.r, rsp_pte_s.w, rsp_pte_s.x};
                     state_r       <= e_ptw_done;
                  end
               end
               e_ptw_done, e_ptw_fault: begin
                  miss_ready_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= e_ptw_idle;
               end
               default: begin
                  miss_ready_r <= 1'b1;
                  busy_r       <= 1'b0;
                  mem_req_v_r  <= 1'b0;
                  state_r      <= e_ptw_idle;
               end
            endcase
         end
      end
   end

   assign miss_ready_o    = miss_ready_r;
   assign busy_o          = busy_r;
   assign mem_req_v_o     = mem_req_v_r;
   assign mem_req_paddr_o = mem_req_paddr_r;
   assign tlb_w_v_o       = tlb_w_v_r;
   assign tlb_w_vtag_o    = tlb_w_vtag_r;
   assign tlb_w_entry_o   = tlb_w_entry_r;
   assign ptw_pkt_o       = ptw_pkt_r;

endmodule

// File: tb/tb_bp_be_ptw.sv
// Directed self-checking bench for bp_be_ptw with hand-computed Sv39 walk vectors.
`timescale 1ns/1ps
module tb_bp_be_ptw;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        miss_v;
   logic        miss_ready;
   logic [38:0] miss_vaddr;
   logic        miss_instr;
   logic        miss_store;
   logic [43:0] satp_ppn;
   logic        flush;
   logic        busy;
   logic        mem_req_v;
   logic        mem_req_ready;
   logic [55:0] mem_req_paddr;
   logic        mem_rsp_v;
   logic [63:0] mem_rsp_data;
   logic        tlb_w_v;
   logic [26:0] tlb_w_vtag;
   logic [50:0] tlb_w_entry;
   logic [41:0] ptw_pkt;

   int tests_run    = 0;
   int tests_failed = 0;

   // vaddr 0x402000: vpn2=0, vpn1=2, vpn0=2
   localparam logic [38:0] va_c       = 39'h00_0040_2000;
   localparam logic [63:0] pte_l2_c   = 64'h0000_0000_2040_00C1; // ppn 0x81000, pointer
   localparam logic [63:0] pte_l1_c   = 64'h0000_0000_2080_00C1; // ppn 0x82000, pointer
   localparam logic [63:0] pte_leaf_c = 64'h0000_0000_048D_14D7; // ppn 0x12345, DAU-RW-V
   localparam logic [50:0] entry_c    = 51'h0_0000_0091_A296;

   always #5 clk = ~clk;

   bp_be_ptw dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .miss_v_i        (miss_v),
      .miss_ready_o    (miss_ready),
      .miss_vaddr_i    (miss_vaddr),
      .miss_instr_i    (miss_instr),
      .miss_store_i    (miss_store),
      .satp_ppn_i      (satp_ppn),
      .flush_i         (flush),
      .busy_o          (busy),
      .mem_req_v_o     (mem_req_v),
      .mem_req_ready_i (mem_req_ready),
      .mem_req_paddr_o (mem_req_paddr),
      .mem_rsp_v_i     (mem_rsp_v),
      .mem_rsp_data_i  (mem_rsp_data),
      .tlb_w_v_o       (tlb_w_v),
      .tlb_w_vtag_o    (tlb_w_vtag),
      .tlb_w_entry_o   (tlb_w_entry),
      .ptw_pkt_o       (ptw_pkt)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic issue_miss(input logic [38:0] va, input logic instr, input logic store,
                             input logic [43:0] ppn);
      miss_v = 1'b1; miss_vaddr = va; miss_instr = instr; miss_store = store; satp_ppn = ppn;
      @(negedge clk);
      miss_v = 1'b0;
   endtask

   // Waits (bounded) for a request, checks its address, optionally stalls, then fires it.
   task automatic serve_req(input string tag, input logic [55:0] exp_paddr, input int ready_delay);
      int          waited = 0;
      logic        stable = 1'b1;
      logic [55:0] first;
      while (!mem_req_v && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_val($sformatf("%s_req_v", tag), {63'd0, mem_req_v}, 64'd1);
      first = mem_req_paddr;
      check_val($sformatf("%s_paddr", tag), {8'd0, first}, {8'd0, exp_paddr});
      repeat (ready_delay) begin
         @(negedge clk);
         if (!mem_req_v || mem_req_paddr !== first) stable = 1'b0;
      end
      if (ready_delay > 0) check_val($sformatf("%s_stable", tag), {63'd0, stable}, 64'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check_val($sformatf("%s_one_req", tag), {63'd0, mem_req_v}, 64'd0);
   endtask

   task automatic respond(input int delay, input logic [63:0] pte);
      repeat (delay) @(negedge clk);
      mem_rsp_v = 1'b1; mem_rsp_data = pte;
      @(negedge clk);
      mem_rsp_v = 1'b0; mem_rsp_data = 64'd0;
   endtask

   task automatic expect_fill(input string tag, input logic [26:0] vtag, input logic [50:0] entry);
      check_val($sformatf("%s_fill_v", tag), {63'd0, tlb_w_v}, 64'd1);
      check_val($sformatf("%s_vtag", tag), {37'd0, tlb_w_vtag}, {37'd0, vtag});
      check_val($sformatf("%s_entry", tag), {13'd0, tlb_w_entry}, {13'd0, entry});
      check_val($sformatf("%s_no_fault", tag), {22'd0, ptw_pkt}, 64'd0);
      @(negedge clk);
      check_val($sformatf("%s_fill_pulse", tag), {63'd0, tlb_w_v}, 64'd0);
      check_val($sformatf("%s_ready", tag), {63'd0, miss_ready}, 64'd1);
   endtask

   task automatic expect_fault(input string tag, input logic [41:0] pkt);
      check_val($sformatf("%s_pkt", tag), {22'd0, ptw_pkt}, {22'd0, pkt});
      check_val($sformatf("%s_no_fill", tag), {63'd0, tlb_w_v}, 64'd0);
      @(negedge clk);
      check_val($sformatf("%s_pkt_pulse", tag), {22'd0, ptw_pkt}, 64'd0);
      check_val($sformatf("%s_ready", tag), {63'd0, miss_ready}, 64'd1);
   endtask

   task automatic walk_to_leaf(input string tag, input logic instr, input logic store);
      issue_miss(va_c, instr, store, 44'h8_0000);
      serve_req($sformatf("%s_l2", tag), 56'h80_0000_0000 >> 8, 0);
      respond(0, pte_l2_c);
      serve_req($sformatf("%s_l1", tag), 56'h81_0000_10, 0);
      respond(0, pte_l1_c);
      serve_req($sformatf("%s_l0", tag), 56'h82_0000_10, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; miss_v = 1'b0; miss_vaddr = 39'd0; miss_instr = 1'b0; miss_store = 1'b0;
      satp_ppn = 44'd0; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_v = 1'b0; mem_rsp_data = 64'd0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", {63'd0, miss_ready}, 64'd1);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_req_v", {63'd0, mem_req_v}, 64'd0);
      check_val("rst_fill", {63'd0, tlb_w_v}, 64'd0);
      check_val("rst_pkt", {22'd0, ptw_pkt}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 4KB walk, root at 0x80000000; vpn2=0 so the root index offset is zero
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      check_val("w4k_busy", {63'd0, busy}, 64'd1);
      check_val("w4k_not_ready", {63'd0, miss_ready}, 64'd0);
      serve_req("w4k_l2", 56'h00_0000_8000_0000, 0);
      respond(2, pte_l2_c);
      serve_req("w4k_l1", 56'h00_0000_8100_0010, 0);
      respond(0, pte_l1_c);
      serve_req("w4k_l0", 56'h00_0000_8200_0010, 0);
      respond(1, pte_leaf_c);
      expect_fill("w4k", 27'h402, entry_c);

      // root index offset 8 when vpn2=1
      issue_miss(39'h00_4040_2000, 1'b0, 1'b0, 44'h8_0000);
      serve_req("vpn2_l2", 56'h00_0000_8000_0008, 0);
      respond(0, 64'd0);
      expect_fault("vpn2", {3'b010, 39'h00_4040_2000});

      // invalid level-1 PTE on a load
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      serve_req("inv_l2", 56'h00_0000_8000_0000, 0);
      respond(0, pte_l2_c);
      serve_req("inv_l1", 56'h00_0000_8100_0010, 0);
      respond(0, 64'd0);
      expect_fault("inv", {3'b010, va_c});

      // 2MB leaf at level 1 (ppn 0x82000, DA-RW-V)
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      serve_req("sp_l2", 56'h00_0000_8000_0000, 0);
      respond(0, pte_l2_c);
      serve_req("sp_l1", 56'h00_0000_8100_0010, 0);
      respond(0, 64'h0000_0000_2080_00C7);
`ifdef BP_BE_PTW_SUPERPAGE_EN
      expect_fill("sp", 27'h402, 51'h0_0000_0410_0026);
`else
      expect_fault("sp", {3'b010, va_c});
`endif

      // misaligned 2MB leaf (ppn 0x82001) faults in every build
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      serve_req("mis_l2", 56'h00_0000_8000_0000, 0);
      respond(0, pte_l2_c);
      serve_req("mis_l1", 56'h00_0000_8100_0010, 0);
      respond(0, 64'h0000_0000_2080_04C7);
      expect_fault("mis", {3'b010, va_c});

      // leaf with D=0: store faults, load fills, instr with A=0 faults
      walk_to_leaf("st", 1'b0, 1'b1);
      respond(0, 64'h0000_0000_048D_1457);
      expect_fault("st", {3'b001, va_c});
      walk_to_leaf("ld", 1'b0, 1'b0);
      respond(0, 64'h0000_0000_048D_1457);
      expect_fill("ld", 27'h402, entry_c);
      walk_to_leaf("if", 1'b1, 1'b1);
      respond(0, 64'h0000_0000_048D_1417);
      expect_fault("if", {3'b100, va_c});

      // ready held low for 5 cycles
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      serve_req("stall_l2", 56'h00_0000_8000_0000, 5);
      respond(0, 64'd0);
      expect_fault("stall", {3'b010, va_c});

      // flush while waiting; the stale response lands in the next walk's WAIT and is dropped
      issue_miss(va_c, 1'b0, 1'b0, 44'h8_0000);
      serve_req("fl_l2", 56'h00_0000_8000_0000, 0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_val("fl_idle", {63'd0, busy}, 64'd0);
      check_val("fl_ready", {63'd0, miss_ready}, 64'd1);
      issue_miss(va_c, 1'b0, 1'b0, 44'h9_0000);
      serve_req("fl2_l2", 56'h00_0000_9000_0000, 0);
      respond(0, pte_leaf_c);
      check_val("fl_drop_pkt", {22'd0, ptw_pkt}, 64'd0);
      check_val("fl_drop_fill", {63'd0, tlb_w_v}, 64'd0);
      check_val("fl_drop_busy", {63'd0, busy}, 64'd1);
      respond(0, 64'h0000_0000_2440_00C1);
      serve_req("fl2_l1", 56'h00_0000_9100_0010, 0);
      respond(0, 64'h0000_0000_2480_00C1);
      serve_req("fl2_l0", 56'h00_0000_9200_0010, 0);
      respond(0, pte_leaf_c);
      expect_fill("fl2", 27'h402, entry_c);

      // flush and miss in the same cycle: miss not accepted
      flush = 1'b1; miss_v = 1'b1; miss_vaddr = va_c; satp_ppn = 44'h8_0000;
      @(negedge clk);
      flush = 1'b0; miss_v = 1'b0;
      check_val("flmiss_busy", {63'd0, busy}, 64'd0);
      check_val("flmiss_req", {63'd0, mem_req_v}, 64'd0);

      // stray response while idle is ignored
      respond(0, pte_leaf_c);
      check_val("stray_fill", {63'd0, tlb_w_v}, 64'd0);
      check_val("stray_busy", {63'd0, busy}, 64'd0);

      // reset coinciding with the final leaf response suppresses the fill
      walk_to_leaf("rst", 1'b0, 1'b0);
      reset_n = 1'b0; mem_rsp_v = 1'b1; mem_rsp_data = pte_leaf_c;
      @(negedge clk);
      reset_n = 1'b1; mem_rsp_v = 1'b0; mem_rsp_data = 64'd0;
      check_val("rstw_fill", {63'd0, tlb_w_v}, 64'd0);
      check_val("rstw_pkt", {22'd0, ptw_pkt}, 64'd0);
      check_val("rstw_ready", {63'd0, miss_ready}, 64'd1);
      check_val("rstw_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check_val("rstw_fill2", {63'd0, tlb_w_v}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
